// File: rtl/idex_stage.sv
// ID/EX pipeline register with valid/ready flow control, optional skid entry,
// synchronous flush, bubble squashing of the control word and a saturating stall counter.
module idex_stage #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int CTRL_W  = 16,
  parameter int SKID    = 1,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  // Handshake: a transfer happens on an edge where valid && ready; valid never
  // depends on ready, and the payload is only meaningful while valid is high.
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [XLEN-1:0]    in_rd1,
  input  logic [XLEN-1:0]    in_rd2,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_pcplus4,
  input  logic [REG_AW-1:0]  in_rs1,
  input  logic [REG_AW-1:0]  in_rs2,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [XLEN-1:0]    out_rd1,
  output logic [XLEN-1:0]    out_rd2,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_pcplus4,
  output logic [REG_AW-1:0]  out_rs1,
  output logic [REG_AW-1:0]  out_rs2,
  output logic [REG_AW-1:0]  out_rd,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int PW = CTRL_W + 5 * XLEN + 3 * REG_AW;

  // Bit 0 is the MAIN valid flag, bit 1 the SKB valid flag, so both come straight from flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } occ_t;

  occ_t            state;
  occ_t            state_next;
  logic [PW-1:0]   main_q;
  logic [PW-1:0]   skb_q;
  logic [PW-1:0]   in_pack;
  logic [CTRL_W-1:0] main_ctrl;
  logic            skb_valid;
  logic            accept;
  logic            xfer;
  logic            main_from_in;
  logic            main_from_skb;
  logic            skb_load;

  assign in_pack   = {in_ctrl, in_rd1, in_rd2, in_pc, in_imm, in_pcplus4, in_rs1, in_rs2, in_rd};
  assign out_valid = state[0];
  assign skb_valid = state[1];

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = !skb_valid;
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    main_from_in  = 1'b0;
    main_from_skb = 1'b0;
    skb_load      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next   = ONE;
            main_from_in = 1'b1;
          end
        end
        ONE: begin
          case ({accept, xfer})
            2'b10: begin
              // Without a skid entry an accept in ONE always coincides with a transfer.
              if (SKID != 0) begin
                state_next = FULL;
                skb_load   = 1'b1;
              end else begin
                main_from_in = 1'b1;
              end
            end
            2'b11:   main_from_in = 1'b1;
            2'b01:   state_next   = EMPTY;
            default: state_next   = ONE;
          endcase
        end
        FULL: begin
          if (xfer) begin
            state_next    = ONE;
            main_from_skb = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skb_q  <= '0;
    end else begin
      if (main_from_skb)     main_q <= skb_q;
      else if (main_from_in) main_q <= in_pack;
      if (skb_load)          skb_q  <= in_pack;
    end
  end

  assign {main_ctrl, out_rd1, out_rd2, out_pc, out_imm, out_pcplus4,
          out_rs1, out_rs2, out_rd} = main_q;

  // Bubbles carry an all-zero control word so no write enable can leak downstream.
  assign out_ctrl = out_valid ? main_ctrl : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage (SKID=1, STALL_W=4): driver tasks push expected
// instructions into a queue, a negedge monitor pops and compares on each out-transfer.
module tb_idex_stage;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int CTRL_W  = 16;
  localparam int STALL_W = 4;
  localparam int EW      = CTRL_W + 2 * XLEN;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [CTRL_W-1:0]  in_ctrl = '0;
  logic [XLEN-1:0]    in_rd1 = '0, in_rd2 = '0, in_pc = '0, in_imm = '0, in_pcplus4 = '0;
  logic [REG_AW-1:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic               flush = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [XLEN-1:0]    out_rd1, out_rd2, out_pc, out_imm, out_pcplus4;
  logic [REG_AW-1:0]  out_rs1, out_rs2, out_rd;
  logic [STALL_W-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];

  idex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .SKID(1), .STALL_W(STALL_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_pc(in_pc), .in_imm(in_imm), .in_pcplus4(in_pcplus4),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_pc(out_pc), .out_imm(out_imm),
    .out_pcplus4(out_pcplus4), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .stall_cnt(stall_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CTRL_W-1:0] ctrl_of(input logic [XLEN-1:0] pc);
    ctrl_of = 16'h8000 | 16'(pc[11:0]);
  endfunction

  function automatic logic [XLEN-1:0] rd1_of(input logic [XLEN-1:0] pc);
    rd1_of = pc ^ 32'hA5A5_0000;
  endfunction

  task automatic drive(input logic [XLEN-1:0] pc);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_ctrl    = ctrl_of(pc);
    in_rd1     = rd1_of(pc);
    in_rd2     = ~pc;
    in_imm     = pc + 32'd16;
    in_pcplus4 = pc + 32'd4;
    in_rs1     = pc[6:2];
    in_rs2     = pc[7:3];
    in_rd      = pc[6:2] ^ 5'h1F;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  // Presents one instruction until accepted; returns at posedge+1 of the accept edge.
  task automatic send(input logic [XLEN-1:0] pc, input bit expect_out);
    bit done = 0;
    drive(pc);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        @(posedge clk);
        #1;
        if (expect_out) exp_q.push_back({ctrl_of(pc), pc, rd1_of(pc)});
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) check("send_timeout", 64'(pc), 64'hFFFF_FFFF);
    idle_in();
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (!out_valid) check("bubble_ctrl", 64'(out_ctrl), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_pc", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [EW-1:0] e;
          logic [XLEN-1:0] epc;
          e   = exp_q.pop_front();
          epc = e[2*XLEN-1:XLEN];
          check("out_pc", 64'(out_pc), 64'(epc));
          check("out_ctrl", 64'(out_ctrl), 64'(e[EW-1:2*XLEN]));
          check("out_rd1", 64'(out_rd1), 64'(e[XLEN-1:0]));
          check("out_pcplus4", 64'(out_pcplus4), 64'(epc + 32'd4));
          check("out_rd", 64'(out_rd), 64'(epc[6:2] ^ 5'h1F));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_rd1", 64'(out_rd1), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // stream 4 instructions at full rate
    out_ready = 1'b1;
    send(32'h0, 1'b1);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("latency_out_pc", 64'(out_pc), 64'h0);
    send(32'h4, 1'b1);
    check("stream_in_ready", 64'(in_ready), 64'd1);
    send(32'h8, 1'b1);
    check("stream_in_ready", 64'(in_ready), 64'd1);
    send(32'hC, 1'b1);
    check("stream_stall_cnt", 64'(stall_cnt), 64'd0);
    cycles(3);

    // stall for 3 cycles with the stage already holding one instruction
    send(32'h10, 1'b1);
    out_ready = 1'b0;
    drive(32'h14);
    @(negedge clk);
    check("stall_c1_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    exp_q.push_back({ctrl_of(32'h14), 32'h14, rd1_of(32'h14)});
    drive(32'h18);
    @(negedge clk);
    check("stall_c2_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_c3_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("stall_cnt_3", 64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    send(32'h18, 1'b1);
    cycles(4);
    check("stall_cnt_hold", 64'(stall_cnt), 64'd3);

    // flush while accepting 0x20 with 0x1C in MAIN
    out_ready = 1'b0;
    send(32'h1C, 1'b0);
    drive(32'h20);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle_in();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    out_ready = 1'b1;
    cycles(3);
    check("flush_stays_empty", 64'(out_valid), 64'd0);
    check("flush_keeps_stall_cnt", 64'(stall_cnt), 64'd4);

    // bubble with RegWrite and MemWrite set on the idle input
    in_valid = 1'b0;
    in_ctrl  = 16'h9000;
    cycles(2);
    check("bubble_out_valid", 64'(out_valid), 64'd0);
    check("bubble_out_ctrl_0", 64'(out_ctrl), 64'd0);
    check("bubble_data_hold", 64'(out_pc), 64'h1C);

    // saturation: 4 -> 15 and stays there
    out_ready = 1'b0;
    send(32'h30, 1'b1);
    cycles(20);
    check("stall_sat", 64'(stall_cnt), 64'd15);
    out_ready = 1'b1;
    cycles(3);
    check("stall_sat_hold", 64'(stall_cnt), 64'd15);

    // async reset while FULL
    out_ready = 1'b0;
    send(32'h40, 1'b0);
    send(32'h44, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("arst_out_pc", 64'(out_pc), 64'd0);
    check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(32'h50, 1'b1);
    check("post_rst_out_valid", 64'(out_valid), 64'd1);
    check("post_rst_out_pc", 64'(out_pc), 64'h50);
    cycles(4);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
# idex_stage

Parametrised ID/EX pipeline stage for the RISC-V core. It replaces the passive decode-to-execute bundle with a registered stage that has valid/ready flow control, an optional skid buffer, synchronous flush and bubble squashing. A saturating stall counter is included. The stage sits between the decode stage (upstream) and the execute stage (downstream); the hazard unit drives `flush`.

## Interface
Parameters:
- `XLEN`, 32: width of RD1, RD2, PC, ImmExt, PCPlus4.
- `REG_AW`, 5: register-address width for Rs1, Rs2, Rd.
- `CTRL_W`, 16: width of the packed control word (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, SrcAsrc, funct3, jumpReg).
- `SKID`, 1: 1 selects a two-entry stage with registered `in_ready`; 0 selects a one-entry stage with combinational `in_ready`.
- `STALL_W`, 16: width of the stall counter.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  clock.
  - `reset`  in  1  asynchronous, active-high reset.
- Upstream side:
  - `in_valid`  in  1  decode presents an instruction.
  - `in_ready`  out  1  stage accepts this cycle.
  - `in_ctrl`  in  CTRL_W  control word; bit CTRL_W-1 is RegWrite, bit CTRL_W-4 is MemWrite.
  - `in_rd1`, `in_rd2`, `in_pc`, `in_imm`, `in_pcplus4`  in  XLEN each  operand, PC and immediate data.
  - `in_rs1`, `in_rs2`, `in_rd`  in  REG_AW each  register addresses.
- Control:
  - `flush`  in  1  kill every instruction held in the stage.
- Downstream side:
  - `out_valid`  out  1  execute-side instruction valid.
  - `out_ready`  in  1  execute consumes this cycle.
  - `out_ctrl`, `out_rd1`, `out_rd2`, `out_pc`, `out_imm`, `out_pcplus4`, `out_rs1`, `out_rs2`, `out_rd`  out  matching widths  registered copies of the inputs.
- Status:
  - `stall_cnt`  out  STALL_W  number of cycles with `out_valid && !out_ready`; saturates.

## Operation
- Handshakes:
  - Transfer in: `in_valid && in_ready`.
  - Transfer out: `out_valid && out_ready`.
  - Every accepted instruction appears on the outputs exactly once, in order.
- SKID=0 (one entry, MAIN):
  - `in_ready = !out_valid || out_ready`.
  - On accept, MAIN loads the inputs.
- SKID=1 (two entries, MAIN and SKB):
  - `in_ready = !skb_valid`, taken directly from a flop.
  - If input is accepted while MAIN is valid and not consumed, the input goes to SKB.
  - On an out-transfer with SKB valid, SKB moves to MAIN and SKB clears.
  - Output always comes from MAIN.
- Occupancy states for SKID=1:
  - EMPTY: MAIN invalid.
  - ONE: MAIN valid, SKB invalid.
  - FULL: MAIN and SKB valid.
- State transitions:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on out-transfer without accept.
  - ONE → ONE on both accept and out-transfer, or on neither.
  - ONE → FULL on accept without out-transfer.
  - FULL → ONE on out-transfer; no accept is possible while FULL.
- Flush:
  - Synchronous; all valid bits clear at the next edge.
  - An instruction accepted in the flush cycle is discarded.
  - `in_ready` follows the normal rule during flush.
- Bubble squash:
  - `out_ctrl` is all-zero whenever `out_valid=0`, so RegWrite and MemWrite never assert on a bubble.
  - Data outputs hold their last value while invalid; they are not zeroed.
- Stall counter:
  - Increments by 1 in every cycle where `out_valid && !out_ready`.
  - Holds at 2^STALL_W−1.
  - Cleared only by reset; flush does not clear it.

## Timing
- Latency: one cycle from accept to `out_valid` when the stage was EMPTY.
- Throughput: one instruction per cycle while `out_ready=1`.
- Reset (asynchronous, while `reset` is high):
  - `out_valid=0`, `out_ctrl=0`, all data outputs 0, `stall_cnt=0`.
  - `in_ready=1` for both SKID values.
- Reset mid-operation: held instructions are lost with no partial output; the first cycle after release behaves as EMPTY.
- Flush and out_ready together: flush wins; the downstream may sample MAIN in that cycle, but the stage state is EMPTY afterwards.
- Stall counter visibility: `stall_cnt` updates at the edge following the stalled cycle.

## Test plan
- Stream 4 instructions (PC 0x0, 0x4, 0x8, 0xC) with `out_ready=1` → `out_valid` appears one cycle after each accept; `out_pc` sequence is 0x0, 0x4, 0x8, 0xC; `in_ready` stays 1.
- SKID=1, drop `out_ready` for 3 cycles while `in_valid=1` → two instructions held; `in_ready=0` from the second cycle; no loss or duplication after release; `stall_cnt=3`.
- Flush in the same cycle as accepting PC 0x20 with MAIN holding PC 0x1C → next cycle `out_valid=0` and `out_ctrl=0`; PC 0x1C and 0x20 never appear on the outputs.
- Input `in_ctrl` has RegWrite=1 and MemWrite=1 but `in_valid=0` → `out_valid=0`, `out_ctrl=0x0000`.
- STALL_W=4, hold the stage valid with `out_ready=0` for 20 cycles → `stall_cnt` reaches 15 and stays there.
- Assert `reset` asynchronously mid-stall in FULL state → all outputs go to 0 immediately; after release, `in_ready=1` and a new instruction appears after 1 cycle.
